uart_rx_core: RTL

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_pkg.sv | 47 ++++
 rtl/baud_controller_receiver.sv | 36 +++
 rtl/uart_rx_core.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud codes, oversampling divisor and receiver state encoding.
// The transmitter uses the same baud codes and divisor function.
package uart_pkg;

  localparam logic [2:0] BAUD_300    = 3'd0;
  localparam logic [2:0] BAUD_1200   = 3'd1;
  localparam logic [2:0] BAUD_4800   = 3'd2;
  localparam logic [2:0] BAUD_9600   = 3'd3;
  localparam logic [2:0] BAUD_19200  = 3'd4;
  localparam logic [2:0] BAUD_38400  = 3'd5;
  localparam logic [2:0] BAUD_57600  = 3'd6;
  localparam logic [2:0] BAUD_115200 = 3'd7;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  function automatic int baud_rate(input logic [2:0] code);
    case (code)
      BAUD_300:    return 300;
      BAUD_1200:   return 1200;
      BAUD_4800:   return 4800;
      BAUD_9600:   return 9600;
      BAUD_19200:  return 19200;
      BAUD_38400:  return 38400;
      BAUD_57600:  return 57600;
      default:     return 115200;
    endcase
  endfunction

  // Clocks per sample tick, rounded to nearest; never below one clock.
  function automatic int baud_divisor(input int clk_freq, input logic [2:0] code);
    int b;
    int d;
    b = baud_rate(code);
    d = (clk_freq + (OVERSAMPLE / 2) * b) / (OVERSAMPLE * b);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/baud_controller_receiver.sv
// Free-running divider producing a one-clock sample tick at 16x the selected baud rate.
module baud_controller_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] Rx_baud_select,
  output logic       Rx_sample_ENABLE
);

  localparam int CW = $clog2(baud_divisor(CLK_FREQ, BAUD_300) + 1);

  logic [CW-1:0] div_cnt;
  logic [CW-1:0] div_last;

  always_comb begin
    div_last = CW'(baud_divisor(CLK_FREQ, Rx_baud_select) - 1);
  end

  // >= rather than == so a switch to a faster rate wraps immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt          <= '0;
      Rx_sample_ENABLE <= 1'b0;
    end else if (div_cnt >= div_last) begin
      div_cnt          <= '0;
      Rx_sample_ENABLE <= 1'b1;
    end else begin
      div_cnt          <= div_cnt + 1'b1;
      Rx_sample_ENABLE <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, 16x oversampled.
// Rx_VALID is a one-clock pulse; Rx_PERROR/Rx_FERROR are meaningful only with it.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  input  logic       Rx_EN,
  input  logic [2:0] Rx_baud_select,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR,
  output rx_state_t  rx_state
);

  rx_state_t  state, state_next;
  logic       rx_meta, rx_sync, rx_prev;
  logic [2:0] baud_lat;
  logic       tick;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par_bit;
  logic       fall, sample_pt;
  logic       start_det, shift_en, par_en, frame_done, frame_ferr;

  baud_controller_receiver #(.CLK_FREQ(CLK_FREQ)) u_baud (
    .clk              (clk),
    .reset            (reset),
    .Rx_baud_select   (baud_lat),
    .Rx_sample_ENABLE (tick)
  );

  // rx_prev is the edge-detect history, not a third synchronizer stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall      = rx_prev & ~rx_sync;
  assign sample_pt = tick && (tick_cnt == ((state == ST_START) ? 4'd7 : 4'd15));
  assign rx_state  = state;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    frame_done = 1'b0;
    frame_ferr = 1'b0;
    case (state)
      ST_IDLE: if (fall) begin
        state_next = ST_START;
        start_det  = 1'b1;
      end
      ST_START: if (sample_pt) state_next = rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA: if (sample_pt) begin
        shift_en = 1'b1;
        if (bit_cnt == 3'd7) state_next = ST_PARITY;
      end
      ST_PARITY: if (sample_pt) begin
        par_en     = 1'b1;
        state_next = ST_STOP;
      end
      ST_STOP: if (sample_pt) begin
        frame_done = 1'b1;
        if (rx_sync) begin
          state_next = ST_IDLE;
        end else begin
          frame_ferr = 1'b1;
          state_next = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: if (rx_sync) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Disable overrides everything, including a completing frame.
    if (!Rx_EN) begin
      state_next = ST_IDLE;
      start_det  = 1'b0;
      shift_en   = 1'b0;
      par_en     = 1'b0;
      frame_done = 1'b0;
      frame_ferr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_lat  <= BAUD_115200;
      tick_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      par_bit   <= 1'b0;
      Rx_DATA   <= 8'h00;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      Rx_VALID  <= frame_done;
      Rx_PERROR <= frame_done & ((^shreg) ^ par_bit);
      Rx_FERROR <= frame_ferr;
      if (frame_done) Rx_DATA <= shreg;
      if (start_det) begin
        baud_lat <= Rx_baud_select;
        tick_cnt <= 4'd0;
        bit_cnt  <= 3'd0;
      end else if (tick && state != ST_IDLE && state != ST_WAIT_IDLE) begin
        tick_cnt <= sample_pt ? 4'd0 : tick_cnt + 4'd1;
      end
      if (shift_en) begin
        shreg   <= {rx_sync, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_en) par_bit <= rx_sync;
    end
  end

endmodule
